// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the iterative divider
// Purpose: FSM state encoding, default operand width and the divide-by-zero
//          quotient pattern used by iter_divider and div_step.
// Ports:   none (package).
package div_pkg;

  localparam int WIDTH_DEF = 32;

  // Quotient returned when the divisor is zero (all ones at WIDTH_DEF).
  localparam logic [WIDTH_DEF-1:0] DZ_QUOT = '1;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring division step
// Purpose: shifts {r, q} left by one, trial-subtracts the divisor magnitude
//          and either keeps the difference (quotient bit 1) or restores.
// Ports:   r, q    - current partial remainder / partial quotient
//          d       - divisor magnitude
//          r_next  - partial remainder after this step
//          q_next  - partial quotient after this step
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {r, q[WIDTH-1]};

  // Subtraction as an adder: shifted + ~{0,d} + carry-in 1, at WIDTH+1 bits.
  // Since r < d on entry, shifted < 2d, so trial[WIDTH] is a true sign bit.
  assign trial = shifted + {1'b1, ~d} + (WIDTH+1)'(1);

  assign q_next = {q[WIDTH-2:0], ~trial[WIDTH]};
  assign r_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - sequential radix-2 restoring divider, signed/unsigned
// Purpose: accepts a dividend/divisor pair, produces one quotient bit per clock
//          and returns quotient/remainder with fixed latency WIDTH+2.
// Ports:   clk, rst_n                 - clock, synchronous active-low reset
//          in_valid/in_ready, a, b,
//          signed_op                  - operand handshake and operands
//          out_valid/out_ready,
//          quotient, remainder,
//          div_by_zero                - result handshake and result
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t state, next_state;

  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn;
  logic [WIDTH-1:0] r_q, q_q, dmag;
  logic             neg_q, neg_r, dz;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] r_next, q_next;

  // Magnitudes; the most negative value maps to itself, which is its correct
  // unsigned magnitude, so overflow needs no special handling.
  assign a_mag = (sgn && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_mag = (sgn && b_q[WIDTH-1]) ? -b_q : b_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_q),
    .q      (q_q),
    .d      (dmag),
    .r_next (r_next),
    .q_next (q_next)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = PREP;
      PREP:    next_state = CALC;
      CALC:    if (cnt == CNT_W'(1)) next_state = FIX;
      FIX:     next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sgn         <= 1'b0;
      r_q         <= '0;
      q_q         <= '0;
      dmag        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      cnt         <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
            sgn <= signed_op;
          end
        end
        PREP: begin
          q_q   <= a_mag;
          dmag  <= b_mag;
          r_q   <= '0;
          neg_q <= sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_r <= sgn & a_q[WIDTH-1];
          dz    <= (b_q == '0);
          cnt   <= CNT_W'(WIDTH);
        end
        CALC: begin
          r_q <= r_next;
          q_q <= q_next;
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          if (dz) begin
            quotient  <= WIDTH'(DZ_QUOT);
            remainder <= a_q;
          end else begin
            quotient  <= neg_q ? -q_q : q_q;
            remainder <= neg_r ? -r_q : r_q;
          end
          div_by_zero <= dz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Sequential radix-2 restoring divider: the inverse operation to the team's 32-bit combinational Booth multiplier.
- Accepts a dividend/divisor pair over a valid/ready handshake and iterates one quotient bit per clock.
- Returns quotient and remainder over a second valid/ready handshake.
- Sits beside the multiplier in the ALU datapath; supports signed and unsigned operation.

Parameters:
- WIDTH, 32: operand, quotient and remainder width.
- CNT_W, $clog2(WIDTH)+1: iteration counter width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  divider can accept operands.
- a  input  WIDTH  dividend.
- b  input  WIDTH  divisor.
- signed_op  input  1  1 = two's-complement divide, 0 = unsigned; sampled with the operands.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- quotient  output  WIDTH  quotient.
- remainder  output  WIDTH  remainder.
- div_by_zero  output  1  divisor was zero for this result.

Behaviour:
- Reset (rst_n = 0 at a clock edge), also mid-operation:
  - State goes to IDLE; in-flight operation discarded.
  - out_valid, quotient, remainder, div_by_zero all become 0; in_ready = 1 after reset.
- States: IDLE, PREP, CALC, FIX, DONE. in_ready = 1 only in IDLE.
- IDLE:
  - On in_valid && in_ready, latch a, b, signed_op; go to PREP.
- PREP (1 cycle):
  - Form magnitudes |a| and |b|; negate only if signed_op and the MSB is set.
  - Record neg_q = signed_op & (a[MSB] ^ b[MSB]); record neg_r = signed_op & a[MSB].
  - Record dz = (b == 0). Clear partial remainder; load counter = WIDTH; go to CALC.
- CALC (exactly WIDTH cycles, also when dz):
  - Each cycle: shift {R, Q} left by 1; trial = R - |b| at WIDTH+1 bits.
  - If trial is non-negative: R = trial, Q[0] = 1; else Q[0] = 0.
  - Decrement counter; at 1 go to FIX.
- FIX (1 cycle):
  - quotient = neg_q ? -Q : Q; remainder = neg_r ? -R : R.
  - If dz: force quotient to all ones and remainder to the original a, overriding the sign fix. div_by_zero = dz.
  - Go to DONE; out_valid = 1.
- Latency: out_valid is high in the cycle WIDTH+2 clocks (34 at default) after the accepting edge. Latency is fixed, independent of operands.
- DONE:
  - Outputs held stable while out_valid && !out_ready.
  - On out_ready: out_valid falls next cycle; return to IDLE.
  - Next operands are accepted no earlier than the following cycle; no back-to-back overlap.
  - out_ready while out_valid = 0 is ignored. in_valid outside IDLE is ignored; the source holds it.
- Signed overflow: -2^31 / -1 gives quotient 0x80000000, remainder 0, div_by_zero 0. This falls out of the magnitude path and needs no special case.
- Sign rules: remainder carries the dividend's sign; |remainder| < |divisor|; a = q*b + r holds for all non-zero b.

Decomposition:
- div_pkg holds:
  - state typedef (enum logic [2:0]: IDLE, PREP, CALC, FIX, DONE);
  - WIDTH default constant;
  - DZ_QUOT constant (all ones).
- One sub-module, div_step: combinational single restoring step.
  - Inputs R, Q, |b|; outputs next R, next Q.
  - Subtractor built from the team's carry-lookahead adder.
  - Instantiated once and reused every CALC cycle.

Test Plan:
- Unsigned 100 / 7, signed_op = 0 -> quotient 14, remainder 2, div_by_zero 0; out_valid exactly 34 cycles after accept.
- Signed -100 / 7 -> quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2). Signed 100 / -7 -> quotient -14, remainder 2.
- Divide by zero: a = 0x12345678, b = 0, both signed_op values -> quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero 1; same 34-cycle latency.
- Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid -> outputs stable, in_ready = 0 throughout. in_valid pulsed with other operands during CALC -> not accepted.
- Reset mid-CALC (cycle 15) -> next cycle out_valid = 0, in_ready = 1. Then 0xFFFFFFFF / 0x10 unsigned -> quotient 0x0FFFFFFF, remainder 0xF.
